chan_err_inject: RTL and testbench

//  Parametrised channel bit-error injector between modulator symbol mapper and demapper.

---
 rtl/chan_err_inject_pkg.sv | 17 +
 rtl/chan_err_inject_if.sv | 26 ++
 rtl/chan_err_inject_lfsr.sv | 32 +++
 rtl/chan_err_inject.sv | 106 ++++++++++
 tb/tb_chan_err_inject.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/chan_err_inject_pkg.sv
// Package for the channel error injector.
//   MODE_*             error-event source selectors for the mode input
//   LFSR_TAPS_DEFAULT  Galois feedback mask for x^16+x^14+x^13+x^11+1
//   ERRCNT_W           width of the saturating injected-error counter
package chan_err_pkg;

  localparam logic [1:0] MODE_BYPASS   = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_BURST    = 2'd2;
  localparam logic [1:0] MODE_RANDOM   = 2'd3;

  // Right-shifting Galois form: polynomial terms x^16,x^14,x^13,x^11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS_DEFAULT = 16'hB400;

  localparam int ERRCNT_W = 16;

endpackage

// File: rtl/chan_err_inject_if.sv
// Symbol stream between the mapper, the error injector and the demapper.
//   din_valid/din          symbol offered to the injector
//   dout_valid/dout        symbol leaving the injector, one clock later
//   err_flag               the symbol on dout carries an injected error
// Modports: master = stream source/sink side, slave = injector side.
interface chan_err_inject_if #(
  parameter int W = 2
) ();

  logic         din_valid;
  logic [W-1:0] din;
  logic         dout_valid;
  logic [W-1:0] dout;
  logic         err_flag;

  modport master (
    output din_valid, din,
    input  dout_valid, dout, err_flag
  );

  modport slave (
    input  din_valid, din,
    output dout_valid, dout, err_flag
  );

endinterface

// File: rtl/chan_err_inject_lfsr.sv
// err_lfsr: Galois LFSR used as the random error-event source.
//   clk    clock, rising edge
//   reset  asynchronous, active-low; loads SEED
//   step   advance one position this clock
//   state  current LFSR contents
// An all-zero state would lock the register, so it is replaced by SEED.
module err_lfsr
  import chan_err_pkg::*;
#(
  parameter int                 LFSR_W = 16,
  parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1,
  parameter logic [LFSR_W-1:0]  TAPS   = LFSR_TAPS_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else if (state == '0) begin
      state <= SEED;
    end else if (step) begin
      state <= (state >> 1) ^ (state[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/chan_err_inject.sv
// chan_err_inject: channel bit-error injector between symbol mapper and demapper.
//   clk, reset                 clock (rising) and asynchronous active-low reset
//   en                         1 = inject per mode; 0 = pass-through, frame counter and LFSR frozen
//   mode                       bypass / periodic / burst / random (see chan_err_pkg)
//   period, offset, burst_len  frame length (0 acts as 1), first errored beat, burst length
//   thresh                     random mode: error when lfsr[7:0] < thresh
//   mask                       bits flipped on an errored beat
//   bus (slave)                din_valid/din in, dout_valid/dout/err_flag out, 1 clock latency
//   err_count                  errored beats since reset, saturating
module chan_err_inject
  import chan_err_pkg::*;
#(
  parameter int                W      = 2,
  parameter int                CNT_W  = 5,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [CNT_W-1:0]    period,
  input  logic [CNT_W-1:0]    offset,
  input  logic [CNT_W-1:0]    burst_len,
  input  logic [7:0]          thresh,
  input  logic [W-1:0]        mask,
  chan_err_inject_if.slave    bus,
  output logic [ERRCNT_W-1:0] err_count
);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  p_eff;
  logic [CNT_W:0]    cnt_x, off_x, end_x;
  logic              in_frame;
  logic              hit;
  logic              step;
  logic              err_next;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_unused;

  assign p_eff    = (period == '0) ? CNT_W'(1) : period;
  // A shrunken period can leave cnt beyond the frame; such a beat never hits.
  assign in_frame = (cnt < p_eff);

  // Burst window is compared one bit wider so offset+burst_len cannot wrap.
  assign cnt_x = {1'b0, cnt};
  assign off_x = {1'b0, offset};
  assign end_x = off_x + {1'b0, burst_len};

  assign step     = bus.din_valid & en;
  assign err_next = bus.din_valid & hit & (mask != '0);

  assign lfsr_unused = ^lfsr[LFSR_W-1:8];

  err_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (step),
    .state (lfsr)
  );

  // NOTE: hit gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    hit = 1'b0;
    if (en) begin
      unique case (mode)
        MODE_BYPASS:   hit = 1'b0;
        MODE_PERIODIC: hit = in_frame && (cnt == offset);
        MODE_BURST:    hit = in_frame && (cnt_x >= off_x) && (cnt_x < end_x);
        MODE_RANDOM:   hit = (lfsr[7:0] < thresh);
        default:       hit = 1'b0;
      endcase
    end
  end

  // Frame counter: advances on enabled beats; >= also recovers from a period decrease.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= (cnt >= p_eff - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Output register and error counter; err_count already includes the beat on dout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.dout_valid <= 1'b0;
      bus.dout       <= '0;
      bus.err_flag   <= 1'b0;
      err_count      <= '0;
    end else begin
      bus.dout_valid <= bus.din_valid;
      bus.dout       <= bus.din ^ (hit ? mask : '0);
      bus.err_flag   <= err_next;
      if (err_next && (err_count != '1)) begin
        err_count <= err_count + ERRCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_chan_err_inject.sv
// Scoreboard bench for chan_err_inject: the stimulus process pushes the expected
// output of each valid beat, a negedge monitor pops and compares.
module tb_chan_err_inject;

  localparam logic [15:0] SEED_M = 16'hACE1;
  localparam logic [15:0] TAPS_M = 16'hB400;  // x^16+x^14+x^13+x^11+1

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        en;
  logic [1:0]  mode;
  logic [4:0]  period, offset, burst_len;
  logic [7:0]  thresh;
  logic [1:0]  mask;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  chan_err_inject_if #(.W(2)) bus ();

  chan_err_inject dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .period    (period),
    .offset    (offset),
    .burst_len (burst_len),
    .thresh    (thresh),
    .mask      (mask),
    .bus       (bus),
    .err_count (err_count)
  );

  typedef struct {
    logic [1:0]  dout;
    logic        err;
    int unsigned cnt;
    longint      stamp;
  } exp_t;

  exp_t        q[$];
  int          compared   = 0;
  int          mismatched = 0;
  longint      cyc        = 0;

  // Reference model state: beats counted while enabled, LFSR value, error total.
  int unsigned m_n;
  logic [15:0] m_lfsr;
  int unsigned m_cnt;

  // Monitor bookkeeping.
  int          out_idx;
  int          err_idx[$];
  bit          log_en = 1'b0;
  bit          log_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hit();
    int p, pos;
    if (!en) return 1'b0;
    p   = (period == 0) ? 1 : int'(period);
    pos = int'(m_n % p);
    case (mode)
      2'd1:    return pos == int'(offset);
      2'd2:    return (pos >= int'(offset)) && (pos < int'(offset) + int'(burst_len));
      2'd3:    return int'(m_lfsr[7:0]) < int'(thresh);
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input bit v, input logic [1:0] d);
    bit   h, e;
    exp_t it;
    bus.din_valid = v;
    bus.din       = d;
    if (v) begin
      h = model_hit();
      e = h && (mask != 0);
      if (e && m_cnt < 65535) m_cnt++;
      it.dout  = d ^ (h ? mask : 2'b00);
      it.err   = e;
      it.cnt   = m_cnt;
      it.stamp = cyc;
      q.push_back(it);
      if (en) begin
        m_n++;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS_M : 16'h0000);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 2'($urandom_range(3)));
  endtask

  task automatic drain();
    int k = 0;
    bus.din_valid = 1'b0;
    while (q.size() != 0 && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  // Asserts reset between clock edges, checks outputs clear at once, releases on a negedge.
  task automatic do_reset();
    reset = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_err_flag", bus.err_flag, 0);
    check("rst_err_count", err_count, 0);
    q.delete();
    m_n = 0;
    m_lfsr = SEED_M;
    m_cnt = 0;
    out_idx = 0;
    err_idx.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.dout_valid) begin
        if (q.size() == 0) begin
          check("spurious_dout_valid", 1, 0);
        end else begin
          exp_t it;
          it = q.pop_front();
          check("dout", bus.dout, it.dout);
          check("err_flag", bus.err_flag, it.err);
          check("err_count", err_count, it.cnt);
          check("latency", cyc, it.stamp + 1);
          if (bus.err_flag) err_idx.push_back(out_idx);
          if (log_en) log_q.push_back(bus.err_flag);
          out_idx++;
        end
      end else begin
        check("idle_err_flag", bus.err_flag, 0);
      end
    end
  end

  initial begin
    bit          pat1[$];
    int unsigned c1;

    en = 1'b1; mode = 2'd0; period = 5'd0; offset = 5'd0; burst_len = 5'd0;
    thresh = 8'd0; mask = 2'd0;
    bus.din_valid = 1'b0; bus.din = 2'd0;
    #2;
    do_reset();

    // 1: legacy periodic profile.
    mode = 2'd1; period = 5'd11; offset = 5'd2; mask = 2'b11;
    beats(33);
    drain();
    check("t1_err_count", err_count, 3);
    check("t1_n_err", err_idx.size(), 3);
    if (err_idx.size() == 3) begin
      check("t1_idx0", err_idx[0], 2);
      check("t1_idx1", err_idx[1], 13);
      check("t1_idx2", err_idx[2], 24);
    end

    // 2: burst clipped at the end of the frame.
    do_reset();
    mode = 2'd2; period = 5'd8; offset = 5'd6; burst_len = 5'd4; mask = 2'b01;
    beats(16);
    drain();
    check("t2_err_count", err_count, 4);
    check("t2_n_err", err_idx.size(), 4);
    if (err_idx.size() == 4) begin
      check("t2_idx0", err_idx[0], 6);
      check("t2_idx1", err_idx[1], 7);
      check("t2_idx2", err_idx[2], 14);
      check("t2_idx3", err_idx[3], 15);
    end

    // 3: gapped input, errors only on every 4th valid beat.
    do_reset();
    mode = 2'd1; period = 5'd4; offset = 5'd0; mask = 2'b10;
    for (int i = 0; i < 32; i++) drive(i % 2 == 0, 2'($urandom_range(3)));
    drain();
    check("t3_err_count", err_count, 4);
    if (err_idx.size() >= 2) begin
      check("t3_idx0", err_idx[0], 0);
      check("t3_idx1", err_idx[1], 4);
    end

    // 4: random mode density and reproducibility after reset.
    do_reset();
    mode = 2'd3; thresh = 8'd64; mask = 2'b01;
    log_q.delete(); log_en = 1'b1;
    beats(4096);
    drain();
    log_en = 1'b0;
    c1 = err_count;
    check("t4_density", (c1 >= 928 && c1 <= 1120), 1);
    pat1 = log_q;
    do_reset();
    log_q.delete(); log_en = 1'b1;
    beats(4096);
    drain();
    log_en = 1'b0;
    check("t4_rerun_count", err_count, c1);
    check("t4_rerun_pattern", (log_q == pat1), 1);

    // 5: en=0 for 5 beats shifts the next error by 5 beats.
    do_reset();
    mode = 2'd1; period = 5'd8; offset = 5'd5; mask = 2'b11;
    beats(3);
    en = 1'b0;
    beats(5);
    en = 1'b1;
    beats(12);
    drain();
    check("t5_n_err", err_idx.size(), 2);
    if (err_idx.size() >= 1) check("t5_idx0", err_idx[0], 10);
    if (err_idx.size() >= 2) check("t5_idx1", err_idx[1], 18);

    // 6: reset mid-burst, then a fresh frame.
    do_reset();
    mode = 2'd2; period = 5'd10; offset = 5'd3; burst_len = 5'd4; mask = 2'b11;
    beats(5);
    #2;
    do_reset();
    beats(10);
    drain();
    check("t6_err_count", err_count, 4);
    if (err_idx.size() >= 1) check("t6_first_err", err_idx[0], 3);

    // 7: every beat errored (period 0 acts as 1) until the counter saturates.
    do_reset();
    mode = 2'd1; period = 5'd0; offset = 5'd0; mask = 2'b01;
    beats(65540);
    drain();
    check("t7_saturated", err_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
